// File: rtl/vm2002_change_dispenser_if.sv
// Change-request, coin-eject, restock and status signals of the vm2002 change dispenser.
// The slave modport is the dispenser; the master modport is the vending FSM / coin mechanism side.
interface vm2002_change_dispenser_if;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       change_ready;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       change_done;
  logic       change_err;
  logic       restock_coins;
  logic [7:0] restock_q;
  logic [7:0] restock_d;
  logic [7:0] restock_n;
  logic       low_coin;

  modport slave (
    input  change_valid, change_amount, coin_ready,
           restock_coins, restock_q, restock_d, restock_n,
    output change_ready, coin_valid, coin_type, change_done, change_err, low_coin
  );

  modport master (
    output change_valid, change_amount, coin_ready,
           restock_coins, restock_q, restock_d, restock_n,
    input  change_ready, coin_valid, coin_type, change_done, change_err, low_coin
  );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// Greedy change dispenser: quarters, then dimes, then nickels, one coin per valid/ready handshake.
// VM2002_COIN_INVENTORY_EN enables tube inventory, restock, shortfall errors and low_coin.
module vm2002_change_dispenser #(
  parameter int INIT_QUARTERS = 8,
  parameter int INIT_DIMES    = 8,
  parameter int INIT_NICKELS  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  vm2002_change_dispenser_if.slave        cd
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_DISPENSE = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

  localparam logic [1:0] COIN_NICKEL  = 2'd1;
  localparam logic [1:0] COIN_DIME    = 2'd2;
  localparam logic [1:0] COIN_QUARTER = 2'd3;

`ifdef VM2002_COIN_INVENTORY_EN
  localparam logic [7:0] INIT_Q   = 8'(INIT_QUARTERS);
  localparam logic [7:0] INIT_D   = 8'(INIT_DIMES);
  localparam logic [7:0] INIT_N   = 8'(INIT_NICKELS);
  localparam logic       INIT_LOW = (INIT_QUARTERS < 2) || (INIT_DIMES < 2) || (INIT_NICKELS < 2);
`else
  localparam logic       INIT_LOW = 1'b0;
  localparam int         unused_init = INIT_QUARTERS + INIT_DIMES + INIT_NICKELS;
`endif

  logic [2:0] state_reg, state_next;
  logic [7:0] amount_reg, amount_next;
  logic [7:0] q_plan_reg, q_plan_next;
  logic [7:0] d_plan_reg, d_plan_next;
  logic [7:0] n_plan_reg, n_plan_next;

  logic       change_ready_reg, coin_valid_reg, change_done_reg, change_err_reg, low_coin_reg;
  logic [1:0] coin_type_reg, coin_type_next;
  logic       low_coin_next;

`ifdef VM2002_COIN_INVENTORY_EN
  logic [7:0] q_cnt_reg, q_cnt_next;
  logic [7:0] d_cnt_reg, d_cnt_next;
  logic [7:0] n_cnt_reg, n_cnt_next;
`else
  logic       unused_restock;
  assign unused_restock = ^{cd.restock_coins, cd.restock_q, cd.restock_d, cd.restock_n};
`endif

  // Greedy plan for the latched amount; the min() against tube counts only exists with inventory.
  logic [7:0] q_want, q_take, r1, d_want, d_take, r2, n_want, n_take, r3;
  logic       bad_multiple;

  always_comb begin
    bad_multiple = (amount_reg % 8'd5) != 8'd0;
    q_want = amount_reg / 8'd25;
`ifdef VM2002_COIN_INVENTORY_EN
    q_take = (q_want < q_cnt_reg) ? q_want : q_cnt_reg;
`else
    q_take = q_want;
`endif
    r1     = amount_reg - 8'd25 * q_take;
    d_want = r1 / 8'd10;
`ifdef VM2002_COIN_INVENTORY_EN
    d_take = (d_want < d_cnt_reg) ? d_want : d_cnt_reg;
`else
    d_take = d_want;
`endif
    r2     = r1 - 8'd10 * d_take;
    n_want = r2 / 8'd5;
`ifdef VM2002_COIN_INVENTORY_EN
    n_take = (n_want < n_cnt_reg) ? n_want : n_cnt_reg;
`else
    n_take = n_want;
`endif
    r3     = r2 - 8'd5 * n_take;
  end

  always_comb begin
    state_next  = state_reg;
    amount_next = amount_reg;
    q_plan_next = q_plan_reg;
    d_plan_next = d_plan_reg;
    n_plan_next = n_plan_reg;
`ifdef VM2002_COIN_INVENTORY_EN
    q_cnt_next  = q_cnt_reg;
    d_cnt_next  = d_cnt_reg;
    n_cnt_next  = n_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
`ifdef VM2002_COIN_INVENTORY_EN
        if (cd.restock_coins) begin
          q_cnt_next = cd.restock_q;
          d_cnt_next = cd.restock_d;
          n_cnt_next = cd.restock_n;
        end
`endif
        if (cd.change_valid && change_ready_reg) begin
          amount_next = cd.change_amount;
          state_next  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad_multiple || (r3 != 8'd0)) begin
          state_next = ST_ERROR;
        end else begin
          q_plan_next = q_take;
          d_plan_next = d_take;
          n_plan_next = n_take;
          state_next  = ((q_take | d_take | n_take) == 8'd0) ? ST_DONE : ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (coin_valid_reg && cd.coin_ready) begin
          case (coin_type_reg)
            COIN_QUARTER: begin
              q_plan_next = q_plan_reg - 8'd1;
`ifdef VM2002_COIN_INVENTORY_EN
              q_cnt_next  = q_cnt_reg - 8'd1;
`endif
            end
            COIN_DIME: begin
              d_plan_next = d_plan_reg - 8'd1;
`ifdef VM2002_COIN_INVENTORY_EN
              d_cnt_next  = d_cnt_reg - 8'd1;
`endif
            end
            default: begin
              n_plan_next = n_plan_reg - 8'd1;
`ifdef VM2002_COIN_INVENTORY_EN
              n_cnt_next  = n_cnt_reg - 8'd1;
`endif
            end
          endcase
          if ((q_plan_next | d_plan_next | n_plan_next) == 8'd0) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE, ST_ERROR: state_next = ST_IDLE;
      default:           state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a plain register.
  always_comb begin
    coin_type_next = 2'b00;
    if (state_next == ST_DISPENSE) begin
      if (q_plan_next != 8'd0)      coin_type_next = COIN_QUARTER;
      else if (d_plan_next != 8'd0) coin_type_next = COIN_DIME;
      else                          coin_type_next = COIN_NICKEL;
    end
`ifdef VM2002_COIN_INVENTORY_EN
    low_coin_next = (q_cnt_next < 8'd2) || (d_cnt_next < 8'd2) || (n_cnt_next < 8'd2);
`else
    low_coin_next = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      amount_reg       <= 8'd0;
      q_plan_reg       <= 8'd0;
      d_plan_reg       <= 8'd0;
      n_plan_reg       <= 8'd0;
      change_ready_reg <= 1'b1;
      coin_valid_reg   <= 1'b0;
      coin_type_reg    <= 2'b00;
      change_done_reg  <= 1'b0;
      change_err_reg   <= 1'b0;
      low_coin_reg     <= INIT_LOW;
`ifdef VM2002_COIN_INVENTORY_EN
      q_cnt_reg        <= INIT_Q;
      d_cnt_reg        <= INIT_D;
      n_cnt_reg        <= INIT_N;
`endif
    end else begin
      state_reg        <= state_next;
      amount_reg       <= amount_next;
      q_plan_reg       <= q_plan_next;
      d_plan_reg       <= d_plan_next;
      n_plan_reg       <= n_plan_next;
      change_ready_reg <= (state_next == ST_IDLE);
      coin_valid_reg   <= (state_next == ST_DISPENSE);
      coin_type_reg    <= coin_type_next;
      change_done_reg  <= (state_next == ST_DONE);
      change_err_reg   <= (state_next == ST_ERROR);
      low_coin_reg     <= low_coin_next;
`ifdef VM2002_COIN_INVENTORY_EN
      q_cnt_reg        <= q_cnt_next;
      d_cnt_reg        <= d_cnt_next;
      n_cnt_reg        <= n_cnt_next;
`endif
    end
  end

  assign cd.change_ready = change_ready_reg;
  assign cd.coin_valid   = coin_valid_reg;
  assign cd.coin_type    = coin_type_reg;
  assign cd.change_done  = change_done_reg;
  assign cd.change_err   = change_err_reg;
  assign cd.low_coin     = low_coin_reg;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Scoreboard bench for vm2002_change_dispenser: expected coins are queued per request and
// popped on every coin handshake; request latency and end pulses are checked per request.
module tb_vm2002_change_dispenser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vm2002_change_dispenser_if cd_if();

  vm2002_change_dispenser #(
    .INIT_QUARTERS(8),
    .INIT_DIMES   (8),
    .INIT_NICKELS (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cd   (cd_if.slave)
  );

  localparam int NICKEL  = 1;
  localparam int DIME    = 2;
  localparam int QUARTER = 3;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int stall_len = 0;
  int stall_cnt = 0;
  int hs_count  = 0;
  int held_type = 0;
  bit stalled_prev = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Coin monitor: at the negedge, valid && ready means a handshake at the coming posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt    = 0;
      stalled_prev = 1'b0;
    end else if (cd_if.coin_valid) begin
      if (stalled_prev) check_val("coin_type_stable", int'(cd_if.coin_type), held_type);
      if (cd_if.coin_ready) begin
        hs_count++;
        if (exp_q.size() == 0) check_val("unexpected_coin", int'(cd_if.coin_type), 0);
        else                   check_val("coin_type", int'(cd_if.coin_type), exp_q.pop_front());
        $display("coin handshake %0d type=%0d", hs_count, cd_if.coin_type);
        stall_cnt    = 0;
        stalled_prev = 1'b0;
      end else begin
        stall_cnt++;
        stalled_prev = 1'b1;
        held_type    = int'(cd_if.coin_type);
      end
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Coin mechanism: holds ready low for stall_len cycles of each pending coin.
  initial begin
    cd_if.coin_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cd_if.coin_ready = (stall_cnt >= stall_len);
    end
  end

`ifdef VM2002_COIN_INVENTORY_EN
  task automatic check_counts(input string tag, input int q, input int d, input int n);
    check_val({tag, "_qcnt"}, int'(dut.q_cnt_reg), q);
    check_val({tag, "_dcnt"}, int'(dut.d_cnt_reg), d);
    check_val({tag, "_ncnt"}, int'(dut.n_cnt_reg), n);
  endtask
`endif

  // exp_end: 1 = change_done, 2 = change_err; latency counted in cycles after the accept cycle.
  task automatic run_req(input string name, input int amt, input int exp_end,
                         input int exp_lat, input int exp_coins);
    int cyc;
    int first_valid;
    int end_kind;
    int hs_start;
    @(posedge clk);
    #1;
    check_val({name, "_ready_idle"}, int'(cd_if.change_ready), 1);
    hs_start = hs_count;
    cd_if.change_valid  = 1'b1;
    cd_if.change_amount = amt[7:0];
    @(posedge clk);
    #1;
    cd_if.change_valid = 1'b0;
    cyc = 1;
    first_valid = -1;
    end_kind = 0;
    while (end_kind == 0 && cyc < 200) begin
      @(negedge clk);
      if (cd_if.coin_valid && first_valid < 0) first_valid = cyc;
      if (cd_if.change_done)     end_kind = 1;
      else if (cd_if.change_err) end_kind = 2;
      else check_val({name, "_ready_busy"}, int'(cd_if.change_ready), 0);
      if (end_kind == 0) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check_val({name, "_end_kind"}, end_kind, exp_end);
    check_val({name, "_latency"}, cyc, exp_lat);
    check_val({name, "_first_coin"}, first_valid, (exp_coins > 0) ? 2 : -1);
    check_val({name, "_coin_count"}, hs_count - hs_start, exp_coins);
    check_val({name, "_queue_left"}, exp_q.size(), 0);
    check_val({name, "_ready_end"}, int'(cd_if.change_ready), 0);
    @(posedge clk);
    @(negedge clk);
    check_val({name, "_done_pulse"}, int'(cd_if.change_done), 0);
    check_val({name, "_err_pulse"}, int'(cd_if.change_err), 0);
    check_val({name, "_ready_back"}, int'(cd_if.change_ready), 1);
    $display("request %s amount=%0d end=%0d latency=%0d coins=%0d",
             name, amt, end_kind, cyc, hs_count - hs_start);
    exp_q.delete();
  endtask

  task automatic do_restock(input int q, input int d, input int n);
    @(posedge clk);
    #1;
    cd_if.restock_coins = 1'b1;
    cd_if.restock_q = q[7:0];
    cd_if.restock_d = d[7:0];
    cd_if.restock_n = n[7:0];
    @(posedge clk);
    #1;
    cd_if.restock_coins = 1'b0;
    $display("restock q=%0d d=%0d n=%0d", q, d, n);
  endtask

  initial begin
    int hs_start;
    cd_if.change_valid  = 1'b0;
    cd_if.change_amount = 8'd0;
    cd_if.restock_coins = 1'b0;
    cd_if.restock_q = 8'd0;
    cd_if.restock_d = 8'd0;
    cd_if.restock_n = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_change_ready", int'(cd_if.change_ready), 1);
    check_val("rst_coin_valid", int'(cd_if.coin_valid), 0);
    check_val("rst_coin_type", int'(cd_if.coin_type), 0);
    check_val("rst_change_done", int'(cd_if.change_done), 0);
    check_val("rst_change_err", int'(cd_if.change_err), 0);
    check_val("rst_low_coin", int'(cd_if.low_coin), 0);
`ifdef VM2002_COIN_INVENTORY_EN
    check_counts("rst", 8, 8, 8);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;

    // 40 cents, no backpressure: Q, D, N back to back.
    stall_len = 0;
    exp_q.push_back(QUARTER); exp_q.push_back(DIME); exp_q.push_back(NICKEL);
    run_req("greedy40", 40, 1, 5, 3);
`ifdef VM2002_COIN_INVENTORY_EN
    check_counts("greedy40", 7, 7, 7);
`endif

    // 65 cents with three stall cycles per coin.
    stall_len = 3;
    exp_q.push_back(QUARTER); exp_q.push_back(QUARTER);
    exp_q.push_back(DIME); exp_q.push_back(NICKEL);
    run_req("stall65", 65, 1, 18, 4);
    stall_len = 0;
`ifdef VM2002_COIN_INVENTORY_EN
    check_counts("stall65", 5, 6, 6);
`endif

    run_req("invalid37", 37, 2, 2, 0);
`ifdef VM2002_COIN_INVENTORY_EN
    check_counts("invalid37", 5, 6, 6);
`endif

    run_req("zero", 0, 1, 2, 0);

    // Reset after the first of three quarters has been handshaked.
    exp_q.push_back(QUARTER); exp_q.push_back(QUARTER); exp_q.push_back(QUARTER);
    hs_start = hs_count;
    @(posedge clk);
    #1;
    cd_if.change_valid  = 1'b1;
    cd_if.change_amount = 8'd75;
    @(posedge clk);
    #1;
    cd_if.change_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_coins_before", hs_count - hs_start, 1);
    check_val("midrst_coin_valid", int'(cd_if.coin_valid), 0);
    check_val("midrst_coin_type", int'(cd_if.coin_type), 0);
    check_val("midrst_change_ready", int'(cd_if.change_ready), 1);
    check_val("midrst_low_coin", int'(cd_if.low_coin), 0);
`ifdef VM2002_COIN_INVENTORY_EN
    check_counts("midrst", 8, 8, 8);
`endif
    $display("reset asserted mid-dispense after %0d coin(s)", hs_count - hs_start);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;

    exp_q.push_back(NICKEL);
    run_req("nickel5", 5, 1, 3, 1);
`ifdef VM2002_COIN_INVENTORY_EN
    check_counts("nickel5", 8, 8, 7);
`endif

    // Greedy shortfall: 30 cents with Q=1, D=3, N=0.
    do_restock(1, 3, 0);
    @(negedge clk);
`ifdef VM2002_COIN_INVENTORY_EN
    check_val("restock_low_coin", int'(cd_if.low_coin), 1);
    check_counts("restock", 1, 3, 0);
    run_req("short30", 30, 2, 2, 0);
    check_counts("short30", 1, 3, 0);
    check_val("short30_low_coin", int'(cd_if.low_coin), 1);
`else
    check_val("restock_low_coin", int'(cd_if.low_coin), 0);
    exp_q.push_back(QUARTER); exp_q.push_back(NICKEL);
    run_req("short30", 30, 1, 4, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
